// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, arithmetic helpers and state encoding for the RS(204,188) decoder stages.
package rs_pkg;

  localparam int M = 8;
  localparam int T = 8;
  localparam int N = 204;
  localparam logic [M:0] PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } chien_state_t;

  // Shift-and-add multiply, reducing by the field generator whenever the top bit falls out.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = sh[M-1] ? ((sh << 1) ^ PRIM_POLY[M-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] gf_pow(input int e);
    logic [M-1:0] acc;
    acc = M'(1);
    for (int k = 0; k < (e % 255); k++) acc = gf_mul(acc, M'(2));
    return acc;
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Multiply by a fixed field element: each input bit selects one precomputed column of the XOR matrix.
module gf_const_mul
  import rs_pkg::*;
#(
  parameter logic [M-1:0] CONST = 8'h01
) (
  input  logic [M-1:0] Din,
  output logic [M-1:0] Dout
);

  logic [M-1:0] term [M];

  for (genvar k = 0; k < M; k++) begin : gCol
    localparam logic [M-1:0] COL = gf_mul(CONST, M'(1) << k);
    assign term[k] = Din[k] ? COL : '0;
  end

  always_comb begin
    Dout = '0;
    for (int k = 0; k < M; k++) Dout = Dout ^ term[k];
  end

endmodule

// File: rtl/chien_search.sv
// Chien search: evaluates the latched error locator at alpha^-i for every codeword position, one per clock.
module chien_search
  import rs_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [M-1:0] Sigma1,
  input  logic [M-1:0] Sigma2,
  input  logic [M-1:0] Sigma3,
  input  logic [M-1:0] Sigma4,
  input  logic [M-1:0] Sigma5,
  input  logic [M-1:0] Sigma6,
  input  logic [M-1:0] Sigma7,
  input  logic [M-1:0] Sigma8,
  output logic         Busy,
  output logic         Loc_Valid,
  output logic [7:0]   Loc_Index,
  output logic         Err_Flag,
  output logic         Done,
  output logic [3:0]   Err_Count,
  output logic         Fail
);

  if (N > 255) begin : gLengthCheck
    $error("chien_search: N must not exceed 255");
  end

  chien_state_t state;
  logic [M-1:0] sigmaIn  [1:T];
  logic [M-1:0] coef     [1:T];
  logic [M-1:0] coefNext [1:T];
  logic [M-1:0] sum;
  logic [3:0]   degIn;
  logic [3:0]   deg;
  logic [7:0]   pos;

  assign sigmaIn[1] = Sigma1;
  assign sigmaIn[2] = Sigma2;
  assign sigmaIn[3] = Sigma3;
  assign sigmaIn[4] = Sigma4;
  assign sigmaIn[5] = Sigma5;
  assign sigmaIn[6] = Sigma6;
  assign sigmaIn[7] = Sigma7;
  assign sigmaIn[8] = Sigma8;

  // Term j advances by alpha^-j = alpha^(255-j) each step, so after i steps it holds s_j * alpha^(-i*j).
  for (genvar j = 1; j <= T; j++) begin : gStep
    gf_const_mul #(.CONST(gf_pow(255 - j))) uStep (
      .Din  (coef[j]),
      .Dout (coefNext[j])
    );
  end

  always_comb begin
    sum = M'(1);
    for (int j = 1; j <= T; j++) sum = sum ^ coef[j];
  end

  always_comb begin
    degIn = '0;
    for (int j = 1; j <= T; j++) begin
      if (sigmaIn[j] != '0) degIn = 4'(j);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Loc_Valid <= 1'b0;
      Loc_Index <= '0;
      Err_Flag  <= 1'b0;
      Done      <= 1'b0;
      Err_Count <= '0;
      Fail      <= 1'b0;
      deg       <= '0;
      pos       <= '0;
      for (int j = 1; j <= T; j++) coef[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          Done      <= 1'b0;
          Loc_Valid <= 1'b0;
          Err_Flag  <= 1'b0;
          // Busy is still high during the Done cycle, which keeps a Start there from being accepted.
          if (Start && !Busy) begin
            for (int j = 1; j <= T; j++) coef[j] <= sigmaIn[j];
            deg       <= degIn;
            pos       <= '0;
            Err_Count <= '0;
            Fail      <= 1'b0;
            Busy      <= 1'b1;
            state     <= RUN;
          end else begin
            Busy <= 1'b0;
          end
        end
        RUN: begin
          Loc_Valid <= 1'b1;
          Loc_Index <= pos;
          Err_Flag  <= (sum == '0);
          if ((sum == '0) && (Err_Count != 4'hF)) Err_Count <= Err_Count + 4'd1;
          for (int j = 1; j <= T; j++) coef[j] <= coefNext[j];
          pos <= pos + 8'd1;
          if (pos == 8'(N - 1)) state <= FIN;
        end
        FIN: begin
          Loc_Valid <= 1'b0;
          Err_Flag  <= 1'b0;
          Done      <= 1'b1;
          Fail      <= (Err_Count != deg);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chien_search.sv
// Randomized scoreboard bench for chien_search against a log/antilog-table GF(2^8) reference model.
module tb_chien_search;

  localparam int NPOS = 204;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] Sigma1, Sigma2, Sigma3, Sigma4, Sigma5, Sigma6, Sigma7, Sigma8;
  logic       Busy;
  logic       Loc_Valid;
  logic [7:0] Loc_Index;
  logic       Err_Flag;
  logic       Done;
  logic [3:0] Err_Count;
  logic       Fail;

  chien_search dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Sigma1    (Sigma1),
    .Sigma2    (Sigma2),
    .Sigma3    (Sigma3),
    .Sigma4    (Sigma4),
    .Sigma5    (Sigma5),
    .Sigma6    (Sigma6),
    .Sigma7    (Sigma7),
    .Sigma8    (Sigma8),
    .Busy      (Busy),
    .Loc_Valid (Loc_Valid),
    .Loc_Index (Loc_Index),
    .Err_Flag  (Err_Flag),
    .Done      (Done),
    .Err_Count (Err_Count),
    .Fail      (Fail)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int idx; int flag; int cyc; } locExp_t;
  typedef struct { int cnt; int fail; int cyc; } doneExp_t;

  locExp_t  locQ  [$];
  doneExp_t doneQ [$];
  int testCount = 0;
  int failCount = 0;
  int expTab [0:254];
  int logTab [0:255];
  int sigVec [1:8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic buildTables();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      expTab[i] = v;
      logTab[v] = i;
      v = v * 2;
      if (v >= 256) v = v ^ 'h11D;
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return expTab[(logTab[a] + logTab[b]) % 255];
  endfunction

  // Horner evaluation of 1 + s1 x + .. + s8 x^8 at x = alpha^-i.
  function automatic int evalAt(input int i);
    int x;
    int acc;
    x = expTab[(255 - (i % 255)) % 255];
    acc = 0;
    for (int j = 8; j >= 1; j--) acc = gmul(acc ^ sigVec[j], x);
    return 1 ^ acc;
  endfunction

  task automatic clearSig();
    for (int j = 1; j <= 8; j++) sigVec[j] = 0;
  endtask

  task automatic setRoots(input int roots[$]);
    int c [0:8];
    int p;
    for (int k = 0; k <= 8; k++) c[k] = 0;
    c[0] = 1;
    foreach (roots[r]) begin
      p = expTab[roots[r] % 255];
      for (int k = 8; k >= 1; k--) c[k] = c[k] ^ gmul(p, c[k-1]);
    end
    for (int j = 1; j <= 8; j++) sigVec[j] = c[j];
  endtask

  task automatic randomRoots(input int lo, input int hi, input int maxRoots);
    int roots [$];
    int n;
    int r;
    bit dup;
    n = $urandom_range(maxRoots, 0);
    while (roots.size() < n) begin
      r = $urandom_range(hi, lo);
      dup = 0;
      foreach (roots[k]) if (roots[k] == r) dup = 1;
      if (!dup) roots.push_back(r);
    end
    setRoots(roots);
  endtask

  task automatic driveSigma();
    Sigma1 = 8'(sigVec[1]);
    Sigma2 = 8'(sigVec[2]);
    Sigma3 = 8'(sigVec[3]);
    Sigma4 = 8'(sigVec[4]);
    Sigma5 = 8'(sigVec[5]);
    Sigma6 = 8'(sigVec[6]);
    Sigma7 = 8'(sigVec[7]);
    Sigma8 = 8'(sigVec[8]);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " Busy"}, int'(Busy), 0);
    checkOutput({name, " Loc_Valid"}, int'(Loc_Valid), 0);
    checkOutput({name, " Loc_Index"}, int'(Loc_Index), 0);
    checkOutput({name, " Err_Flag"}, int'(Err_Flag), 0);
    checkOutput({name, " Done"}, int'(Done), 0);
    checkOutput({name, " Err_Count"}, int'(Err_Count), 0);
    checkOutput({name, " Fail"}, int'(Fail), 0);
  endtask

  // Queue the full expected response, pulse Start, then optionally re-pulse Start or assert Reset mid-run.
  task automatic applyStimulus(input string name, input int midStart, input int resetAt);
    int c0;
    int cnt;
    int deg;
    int flag;
    int guard;
    bit aborted;
    driveSigma();
    c0 = cyc + 1;
    cnt = 0;
    deg = 0;
    for (int j = 1; j <= 8; j++) if (sigVec[j] != 0) deg = j;
    for (int i = 0; i < NPOS; i++) begin
      flag = (evalAt(i) == 0) ? 1 : 0;
      cnt += flag;
      locQ.push_back('{i, flag, c0 + 1 + i});
    end
    if (cnt > 15) cnt = 15;
    doneQ.push_back('{cnt, (cnt != deg) ? 1 : 0, c0 + NPOS + 1});
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checkOutput({name, " Busy after Start"}, int'(Busy), 1);
    checkOutput({name, " Err_Count cleared"}, int'(Err_Count), 0);
    aborted = 0;
    guard = 0;
    while (doneQ.size() != 0 && guard < NPOS + 20) begin
      if (midStart >= 0 && cyc == c0 + 1 + midStart) begin
        Start = 1'b1;
        Sigma1 = 8'($urandom_range(255, 1));
        Sigma8 = 8'($urandom_range(255, 1));
      end
      if (resetAt >= 0 && cyc == c0 + 1 + resetAt) Reset = 1'b1;
      tick();
      Start = 1'b0;
      if (Reset) begin
        Reset = 1'b0;
        locQ.delete();
        doneQ.delete();
        aborted = 1;
        checkAllZero({name, " after abort"});
      end
      guard++;
    end
    if (doneQ.size() != 0) begin
      checkOutput({name, " Done within budget"}, 0, 1);
      locQ.delete();
      doneQ.delete();
    end else if (aborted) begin
      repeat (5) tick();
      checkOutput({name, " idle after abort"}, int'(Busy), 0);
    end else begin
      checkOutput({name, " Busy dropped"}, int'(Busy), 0);
      checkOutput({name, " Done one cycle"}, int'(Done), 0);
      checkOutput({name, " Err_Count held"}, int'(Err_Count), cnt);
      checkOutput({name, " leftover positions"}, locQ.size(), 0);
    end
  endtask

  initial begin : monitor
    locExp_t  le;
    doneExp_t de;
    forever begin
      @(negedge Clk);
      if (Loc_Valid === 1'b1) begin
        if (locQ.size() == 0) begin
          checkOutput("unexpected Loc_Valid", 1, 0);
        end else begin
          le = locQ.pop_front();
          checkOutput($sformatf("pos %0d index", le.idx), int'(Loc_Index), le.idx);
          checkOutput($sformatf("pos %0d flag", le.idx), int'(Err_Flag), le.flag);
          checkOutput($sformatf("pos %0d cycle", le.idx), cyc, le.cyc);
          checkOutput($sformatf("pos %0d busy", le.idx), int'(Busy), 1);
        end
      end
      if (Done === 1'b1) begin
        if (doneQ.size() == 0) begin
          checkOutput("unexpected Done", 1, 0);
        end else begin
          de = doneQ.pop_front();
          checkOutput("done Err_Count", int'(Err_Count), de.cnt);
          checkOutput("done Fail", int'(Fail), de.fail);
          checkOutput("done cycle", cyc, de.cyc);
          checkOutput("done busy", int'(Busy), 1);
        end
      end
    end
  end

  initial begin : driver
    int roots [$];
    Reset = 1'b1;
    Start = 1'b0;
    clearSig();
    driveSigma();
    buildTables();
    repeat (3) tick();
    checkAllZero("reset");
    Reset = 1'b0;
    tick();

    clearSig();
    applyStimulus("zero sigma", -1, -1);

    clearSig();
    sigVec[1] = expTab[5];
    applyStimulus("single root 5", -1, -1);

    roots = '{0, 203};
    setRoots(roots);
    applyStimulus("roots 0,203", -1, -1);

    roots = '{1, 17, 40, 88, 120, 150, 199, 202};
    setRoots(roots);
    applyStimulus("eight roots", -1, -1);

    clearSig();
    sigVec[1] = expTab[230];
    applyStimulus("root outside N", -1, -1);

    randomRoots(0, 203, 8);
    applyStimulus("ignored Start", 50, -1);

    randomRoots(0, 99, 8);
    applyStimulus("abort", 50, 100);

    randomRoots(0, 203, 8);
    applyStimulus("after abort", -1, -1);

    for (int k = 0; k < 6; k++) begin
      randomRoots(0, 254, 8);
      applyStimulus($sformatf("random roots %0d", k), -1, -1);
    end

    for (int k = 0; k < 3; k++) begin
      for (int j = 1; j <= 8; j++) sigVec[j] = $urandom_range(255, 0);
      applyStimulus($sformatf("random coef %0d", k), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
